// File: rtl/vec_seq_pkg.sv
// Shared types and constants for the lane-serial vector op sequencer.
// One 32-bit ALU lane is time-multiplexed across the five vector lanes.
package vec_seq_pkg;

  localparam int WIDTH   = 32;
  localparam int LANES   = 5;
  localparam int RADDR_W = 4;
  localparam int CNT_W   = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/vec_op_sequencer_lane_ctr.sv
// Loadable, hold-able lane counter with a terminal-count flag.
// Saturates at the last lane so it never wraps.
module vec_lane_ctr
  import vec_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             hold,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == CNT_W'(LANES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !hold && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vec_op_sequencer.sv
// Executes one vector op lane by lane: a read stage feeding an
// execute/writeback stage, with the two stages overlapped.
module vec_op_sequencer
  import vec_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [RADDR_W-1:0] req_src,
  input  logic [RADDR_W-1:0] req_dst,
  input  logic [WIDTH-1:0]   req_imm,
  input  logic               hold,
  output logic [RADDR_W-1:0] rd_addr,
  output logic [2:0]         rd_lane,
  input  logic [WIDTH-1:0]   rd_data,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  output logic               wr_en,
  output logic [RADDR_W-1:0] wr_addr,
  output logic [2:0]         wr_lane,
  output logic [WIDTH-1:0]   wr_data,
  output logic               busy,
  output logic               done,
  output logic               zero_all
);

  state_t state;
  state_t state_nxt;

  logic [2:0]         op_q;
  logic [RADDR_W-1:0] src_q;
  logic [RADDR_W-1:0] dst_q;
  logic [WIDTH-1:0]   imm_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2:0]         wr_lane_q;
  logic [2:0]         rd_cnt;
  logic               wr_vld;
  logic               zero_acc;
  logic               rd_tc;

  logic accept;
  logic run_go;
  logic drain_go;
  logic wr_act;
  logic zero_nxt;

  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE) && !hold;
  assign accept    = req_ready && req_valid;
  assign run_go    = (state == RUN) && !hold;
  assign drain_go  = (state == DRAIN) && !hold;
  assign wr_act    = busy && wr_vld;
  assign wr_en     = wr_act && !hold;
  assign zero_nxt  = zero_acc && (alu_result == '0);

  vec_lane_ctr u_rd_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .hold  (hold),
    .en    (state == RUN),
    .cnt   (rd_cnt),
    .tc    (rd_tc)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (run_go && rd_tc) state_nxt = DRAIN;
      DRAIN:   if (!hold) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      opnd_q    <= '0;
      wr_lane_q <= '0;
      wr_vld    <= 1'b0;
      zero_acc  <= 1'b0;
      zero_all  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= drain_go;
      if (accept) begin
        op_q     <= req_op;
        src_q    <= req_src;
        dst_q    <= req_dst;
        imm_q    <= req_imm;
        wr_vld   <= 1'b0;
        zero_acc <= 1'b1;
        zero_all <= 1'b0;
      end
      if (run_go) begin
        opnd_q    <= rd_data;
        wr_lane_q <= rd_cnt;
        wr_vld    <= 1'b1;
      end
      if (wr_en) begin
        zero_acc <= zero_nxt;
      end
      // Last lane's result folds into the flag on the same edge as done.
      if (drain_go) begin
        zero_all <= zero_nxt;
        wr_vld   <= 1'b0;
      end
    end
  end

  assign rd_addr = busy ? src_q : '0;
  assign rd_lane = busy ? rd_cnt : '0;
  assign alu_a   = wr_act ? opnd_q : '0;
  assign alu_b   = wr_act ? imm_q : '0;
  assign alu_op  = wr_act ? op_q : ALU_ADD;
  assign wr_addr = wr_act ? dst_q : '0;
  assign wr_lane = wr_act ? wr_lane_q : '0;
  assign wr_data = alu_result;

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Self-checking bench for vec_op_sequencer with a behavioural
// register file, ALU and lane-level reference model.
module tb_vec_op_sequencer;
  import vec_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [3:0]  req_src;
  logic [3:0]  req_dst;
  logic [31:0] req_imm;
  logic        hold;
  logic [3:0]  rd_addr;
  logic [2:0]  rd_lane;
  logic [31:0] rd_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [2:0]  wr_lane;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        zero_all;

  int checks = 0;
  int failures = 0;

  logic [31:0] vrf [16][8];

  int          wc [$];
  logic [2:0]  wl [$];
  logic [3:0]  wa [$];
  logic [31:0] wd [$];
  logic [31:0] wopa [$];
  int          done_c;
  logic        zero_d;

  always #5 clk = ~clk;

  vec_op_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .req_imm    (req_imm),
    .hold       (hold),
    .rd_addr    (rd_addr),
    .rd_lane    (rd_lane),
    .rd_data    (rd_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_lane    (wr_lane),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .zero_all   (zero_all)
  );

  function automatic logic [31:0] ref_alu(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return 32'h0;
    endcase
  endfunction

  assign rd_data    = vrf[rd_addr][rd_lane];
  assign alu_result = ref_alu(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    if (wr_en) vrf[wr_addr][wr_lane] <= wr_data;
  end

  // Issues one op, records every write and the done cycle.
  // Cycle c is the cycle starting at the c-th edge after accept.
  task automatic run_op(input logic [2:0] op, input logic [3:0] src,
                        input logic [3:0] dst, input logic [31:0] imm,
                        input int hold_at, input int hold_n,
                        input int budget);
    wc.delete(); wl.delete(); wa.delete(); wd.delete(); wopa.delete();
    done_c = -1;
    zero_d = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_src = src;
    req_dst = dst; req_imm = imm; hold = 1'b0;
    @(negedge clk);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      hold = (c >= hold_at) && (c < hold_at + hold_n);
      @(negedge clk);
      if (wr_en) begin
        wc.push_back(c); wl.push_back(wr_lane); wa.push_back(wr_addr);
        wd.push_back(wr_data); wopa.push_back(alu_a);
      end
      if (done) begin
        done_c = c;
        zero_d = zero_all;
        break;
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b0; hold = 1'b0;
    req_op = '0; req_src = '0; req_dst = '0; req_imm = '0;
    repeat (2) @(negedge clk);
    checks += 8;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    if (zero_all !== 1'b0) begin failures++; $display("FAIL rst_zero got=%b exp=0", zero_all); end
    if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    if (rd_lane !== 3'd0 || wr_lane !== 3'd0) begin
      failures++; $display("FAIL rst_lanes got=%0d/%0d exp=0/0", rd_lane, wr_lane);
    end
    if (rd_addr !== 4'd0 || wr_addr !== 4'd0) begin
      failures++; $display("FAIL rst_addr got=%0d/%0d exp=0/0", rd_addr, wr_addr);
    end
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || wr_data !== 32'd0) begin
      failures++; $display("FAIL rst_data got=%h/%h/%h exp=0", alu_a, alu_b, wr_data);
    end
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1; reset = 1'b1; hold = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", req_ready); end
    hold = 1'b0;
  endtask

  task automatic test_add;
    logic [31:0] orig [5];
    for (int i = 0; i < 5; i++) begin vrf[1][i] = 32'(i + 1); orig[i] = 32'(i + 1); end
    run_op(ALU_ADD, 4'd1, 4'd2, 32'd10, 99, 0, 20);
    checks += 3;
    if (wc.size() != 5) begin failures++; $display("FAIL add_count got=%0d exp=5", wc.size()); end
    if (done_c != 6) begin failures++; $display("FAIL add_done got=%0d exp=6", done_c); end
    if (zero_d !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", zero_d); end
    for (int i = 0; i < 5 && i < wc.size(); i++) begin
      checks++;
      if (wd[i] !== orig[i] + 32'd10 || wl[i] !== 3'(i)
          || wa[i] !== 4'd2 || wc[i] != i + 1) begin
        failures++;
        $display("FAIL add_wr%0d got=%0d@l%0d/v%0d/c%0d exp=%0d@l%0d/v2/c%0d",
                 i, wd[i], wl[i], wa[i], wc[i], orig[i] + 32'd10, i, i + 1);
      end
    end
  endtask

  task automatic test_sub_zero;
    for (int i = 0; i < 5; i++) vrf[4][i] = 32'd7;
    run_op(ALU_SUB, 4'd4, 4'd5, 32'd7, 99, 0, 20);
    checks += 3;
    if (done_c != 6) begin failures++; $display("FAIL sub_done got=%0d exp=6", done_c); end
    if (zero_d !== 1'b1) begin failures++; $display("FAIL sub_zero got=%b exp=1", zero_d); end
    if (wd.size() != 5) begin failures++; $display("FAIL sub_count got=%0d exp=5", wd.size()); end
    for (int i = 0; i < wd.size(); i++) begin
      checks++;
      if (wd[i] !== 32'd0) begin failures++; $display("FAIL sub_wr%0d got=%h exp=0", i, wd[i]); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (zero_all !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL sub_zero_hold%0d got=%b/%b exp=1/0", k, zero_all, done);
      end
    end
  endtask

  task automatic test_hold;
    logic [31:0] orig [5];
    int          exp_c [5];
    logic [31:0] imm;
    exp_c = '{1, 2, 3, 7, 8};
    imm = $urandom;
    for (int i = 0; i < 5; i++) begin vrf[6][i] = $urandom; orig[i] = vrf[6][i]; end
    run_op(ALU_ADD, 4'd6, 4'd7, imm, 4, 3, 30);
    checks += 2;
    if (wc.size() != 5) begin failures++; $display("FAIL hold_count got=%0d exp=5", wc.size()); end
    if (done_c != 9) begin failures++; $display("FAIL hold_done got=%0d exp=9", done_c); end
    for (int i = 0; i < 5 && i < wc.size(); i++) begin
      checks++;
      if (wc[i] != exp_c[i] || wl[i] !== 3'(i) || wd[i] !== orig[i] + imm) begin
        failures++;
        $display("FAIL hold_wr%0d got=c%0d/l%0d/%h exp=c%0d/l%0d/%h",
                 i, wc[i], wl[i], wd[i], exp_c[i], i, orig[i] + imm);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [10];
    int acc2, d1, d2, nwr;
    logic [31:0] imm1, imm2;
    imm1 = $urandom; imm2 = $urandom;
    for (int i = 0; i < 5; i++) begin
      vrf[8][i] = $urandom; vrf[10][i] = $urandom;
      exp_d[i] = vrf[8][i] | imm1;
      exp_d[i + 5] = vrf[10][i] - imm2;
    end
    acc2 = -1; d1 = -1; d2 = -1; nwr = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = ALU_ORR; req_src = 4'd8;
    req_dst = 4'd9; req_imm = imm1; hold = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin req_op = ALU_SUB; req_src = 4'd10; req_dst = 4'd11; req_imm = imm2; end
      if (acc2 >= 0 && c == acc2) req_valid = 1'b0;
      @(negedge clk);
      if (wr_en) begin
        if (nwr < 10) begin
          checks++;
          if (wr_data !== exp_d[nwr] || wr_lane !== 3'(nwr % 5)) begin
            failures++;
            $display("FAIL b2b_wr%0d got=%h@l%0d exp=%h@l%0d",
                     nwr, wr_data, wr_lane, exp_d[nwr], nwr % 5);
          end
        end
        nwr++;
      end
      if (done) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
      if (req_valid && req_ready && acc2 < 0) acc2 = c + 1;
      if (d2 >= 0) break;
    end
    req_valid = 1'b0;
    checks += 4;
    if (d1 != 6) begin failures++; $display("FAIL b2b_done1 got=%0d exp=6", d1); end
    if (acc2 != 7) begin failures++; $display("FAIL b2b_accept2 got=%0d exp=7", acc2); end
    if (d2 != 13) begin failures++; $display("FAIL b2b_done2 got=%0d exp=13", d2); end
    if (nwr != 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", nwr); end
  endtask

  task automatic test_reset_mid;
    int nwr, ndone;
    for (int i = 0; i < 5; i++) begin vrf[12][i] = $urandom; vrf[13][i] = 32'hDEAD_0000 + 32'(i); end
    nwr = 0; ndone = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = ALU_ADD; req_src = 4'd12;
    req_dst = 4'd13; req_imm = 32'd1; hold = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (c == 3) reset = 1'b0;
      if (c == 4) reset = 1'b1;
      @(negedge clk);
      if (wr_en) nwr++;
      if (done) ndone++;
      if (c == 3) begin
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
          failures++; $display("FAIL mid_rst_state got=%b/%b exp=0/0", busy, wr_en);
        end
      end
    end
    checks += 4;
    if (nwr != 2) begin failures++; $display("FAIL mid_rst_writes got=%0d exp=2", nwr); end
    if (ndone != 0) begin failures++; $display("FAIL mid_rst_done got=%0d exp=0", ndone); end
    if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", req_ready); end
    if (vrf[13][2] !== 32'hDEAD_0002 || vrf[13][4] !== 32'hDEAD_0004) begin
      failures++; $display("FAIL mid_rst_vrf got=%h/%h exp=dead0002/dead0004", vrf[13][2], vrf[13][4]);
    end
  endtask

  task automatic test_src_eq_dst;
    for (int i = 0; i < 5; i++) vrf[3][i] = 32'hFFFF_FFFF;
    run_op(ALU_AND, 4'd3, 4'd3, 32'h0F, 99, 0, 20);
    checks++;
    if (wd.size() != 5) begin failures++; $display("FAIL same_count got=%0d exp=5", wd.size()); end
    for (int i = 0; i < wd.size(); i++) begin
      checks++;
      if (wd[i] !== 32'h0F || wopa[i] !== 32'hFFFF_FFFF || wa[i] !== 4'd3) begin
        failures++;
        $display("FAIL same_wr%0d got=%h opnd=%h v%0d exp=0000000f opnd=ffffffff v3",
                 i, wd[i], wopa[i], wa[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (vrf[3][i] !== 32'h0F) begin failures++; $display("FAIL same_vrf%0d got=%h exp=f", i, vrf[3][i]); end
    end
  endtask

  task automatic test_random;
    logic [31:0] orig [5];
    logic [31:0] expv [5];
    logic [2:0]  op;
    logic [3:0]  src, dst;
    logic [31:0] imm;
    logic        exp_zero;
    int          h, n;
    for (int t = 0; t < 8; t++) begin
      op = 3'($urandom_range(0, 3));
      src = 4'($urandom_range(0, 15));
      dst = 4'($urandom_range(0, 15));
      imm = $urandom;
      h = $urandom_range(0, 5);
      n = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) op = ALU_SUB;
      for (int i = 0; i < 5; i++) begin
        vrf[src][i] = (op == ALU_SUB && t[0]) ? imm : $urandom;
        orig[i] = vrf[src][i];
      end
      exp_zero = 1'b1;
      for (int i = 0; i < 5; i++) begin
        expv[i] = ref_alu(op, orig[i], imm);
        if (expv[i] != 32'd0) exp_zero = 1'b0;
      end
      run_op(op, src, dst, imm, h, n, 40);
      checks += 3;
      if (done_c != 6 + n) begin failures++; $display("FAIL rnd%0d_done got=%0d exp=%0d", t, done_c, 6 + n); end
      if (zero_d !== exp_zero) begin failures++; $display("FAIL rnd%0d_zero got=%b exp=%b", t, zero_d, exp_zero); end
      if (wd.size() != 5) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=5", t, wd.size()); end
      for (int i = 0; i < 5 && i < wd.size(); i++) begin
        checks++;
        if (wd[i] !== expv[i] || wl[i] !== 3'(i) || wa[i] !== dst
            || (wc[i] >= h && wc[i] < h + n)) begin
          failures++;
          $display("FAIL rnd%0d_wr%0d got=%h@l%0d/v%0d/c%0d exp=%h@l%0d/v%0d hold=%0d+%0d",
                   t, i, wd[i], wl[i], wa[i], wc[i], expv[i], i, dst, h, n);
        end
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 8; l++) vrf[r][l] = 32'h0;
    test_reset();
    test_add();
    test_sub_zero();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_src_eq_dst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
